// File: rtl/io_word_bridge_if.sv
// Pad/core streaming bundle for io_word_bridge: inbound pad beats, inbound/outbound core words,
// outbound pad beats, plus flush/error-clear controls and sticky error flags.
interface io_word_bridge_if #(
    parameter int PAD_W = 11,
    parameter int BEATS = 5
);
    localparam int WORD_W = PAD_W * BEATS;

    logic              flush;
    logic              err_clr;
    logic              in_pad_wenq;
    logic [PAD_W-1:0]  in_pad_wdata;
    logic              in_pad_wfull_n;
    logic              in_word_valid;
    logic [WORD_W-1:0] in_word_data;
    logic              in_word_ready;
    logic              out_word_valid;
    logic [WORD_W-1:0] out_word_data;
    logic              out_word_ready;
    logic              out_pad_deq;
    logic [PAD_W-1:0]  out_pad_rdata;
    logic              out_pad_rempty_n;
    logic              err_overflow;
    logic              err_underflow;

    modport slave (
        input  flush, err_clr, in_pad_wenq, in_pad_wdata, in_word_ready,
               out_word_valid, out_word_data, out_pad_deq,
        output in_pad_wfull_n, in_word_valid, in_word_data, out_word_ready,
               out_pad_rdata, out_pad_rempty_n, err_overflow, err_underflow
    );

    modport master (
        output flush, err_clr, in_pad_wenq, in_pad_wdata, in_word_ready,
               out_word_valid, out_word_data, out_pad_deq,
        input  in_pad_wfull_n, in_word_valid, in_word_data, out_word_ready,
               out_pad_rdata, out_pad_rempty_n, err_overflow, err_underflow
    );
endinterface

// File: rtl/io_word_bridge.sv
// Generic word FIFO with synchronous clear; head reads 0 when empty.
// Latency: push visible at head one cycle later.
// Backpressure: push when full and pop when empty are ignored.
module io_word_bridge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            head_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && (count != (AW+1)'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Pad-to-core bridge: packs BEATS inbound pad beats per word, unpacks outbound words to beats.
// Latency: last inbound beat -> in_word_valid 1 cycle; outbound push -> out_pad_rempty_n 1 cycle.
// Backpressure: wfull_n drops only on a final beat into a full FIFO; out_word_ready = FIFO not full.
module io_word_bridge #(
    parameter int PAD_W     = 11,
    parameter int BEATS     = 5,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    io_word_bridge_if.slave bus
);
    localparam int WORD_W = PAD_W * BEATS;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0]     ib_cnt;
    logic [CW-1:0]     ob_cnt;
    logic [WORD_W-1:0] ib_word;
    logic [WORD_W-1:0] ib_next;
    logic [WORD_W-1:0] out_head;
    logic [NW-1:0]     in_count;
    logic [NW-1:0]     out_count;
    logic [PAD_W-1:0]  ob_beat;
    logic              ib_acc;
    logic              ib_done;
    logic              ob_acc;
    logic              ob_done;
    logic              err_ovf_q;
    logic              err_udf_q;

    // Beat counter to word-slice index; MSB-first order just mirrors the index.
    function automatic logic [CW-1:0] slot(input logic [CW-1:0] c);
        return (LSB_FIRST != 0) ? c : LAST - c;
    endfunction

    assign bus.in_pad_wfull_n = (in_count < NW'(DEPTH)) || (ib_cnt != LAST);
    assign ib_acc  = bus.in_pad_wenq && bus.in_pad_wfull_n;
    assign ib_done = ib_acc && (ib_cnt == LAST);

    always_comb begin
        ib_next = ib_word;
        for (int b = 0; b < BEATS; b++) begin
            if (slot(ib_cnt) == CW'(b)) ib_next[b*PAD_W +: PAD_W] = bus.in_pad_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ib_cnt  <= '0;
            ib_word <= '0;
        end else if (bus.flush) begin
            ib_cnt  <= '0;
            ib_word <= '0;
        end else if (ib_acc) begin
            ib_cnt  <= ib_done ? '0 : ib_cnt + CW'(1);
            ib_word <= ib_done ? '0 : ib_next;
        end
    end

    io_word_bridge_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.flush),
        .push     (ib_done),
        .push_dat (ib_next),
        .pop      (bus.in_word_ready),
        .head_dat (bus.in_word_data),
        .count    (in_count)
    );

    assign bus.in_word_valid = (in_count != '0);

    io_word_bridge_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.flush),
        .push     (bus.out_word_valid),
        .push_dat (bus.out_word_data),
        .pop      (ob_done),
        .head_dat (out_head),
        .count    (out_count)
    );

    assign bus.out_word_ready   = (out_count < NW'(DEPTH));
    assign bus.out_pad_rempty_n = (out_count != '0);
    assign ob_acc  = bus.out_pad_deq && bus.out_pad_rempty_n;
    assign ob_done = ob_acc && (ob_cnt == LAST);

    // Head is already zero when empty, so the selected beat is too.
    always_comb begin
        ob_beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (slot(ob_cnt) == CW'(b)) ob_beat = out_head[b*PAD_W +: PAD_W];
        end
    end

    assign bus.out_pad_rdata = ob_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_cnt <= '0;
        end else if (bus.flush) begin
            ob_cnt <= '0;
        end else if (ob_acc) begin
            ob_cnt <= ob_done ? '0 : ob_cnt + CW'(1);
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= (bus.in_pad_wenq && !bus.in_pad_wfull_n) || (err_ovf_q && !bus.err_clr);
            err_udf_q <= (bus.out_pad_deq && !bus.out_pad_rempty_n) || (err_udf_q && !bus.err_clr);
        end
    end

    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_udf_q;
endmodule

// File: tb/tb_io_word_bridge.sv
// Bench for io_word_bridge: LSB-first and MSB-first instances share stimulus and a queue-level model.
module tb_io_word_bridge;
    localparam int PAD_W  = 11;
    localparam int BEATS  = 5;
    localparam int DEPTH  = 4;
    localparam int WORD_W = PAD_W * BEATS;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PAD_W-1:0]  beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  flush = 1'b0, err_clr = 1'b0, wenq = 1'b0, in_ready = 1'b0, out_valid = 1'b0, deq = 1'b0;
    beat_t wdata = '0;
    word_t out_data = '0;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    io_word_bridge_if #(.PAD_W(PAD_W), .BEATS(BEATS)) b1 ();
    io_word_bridge_if #(.PAD_W(PAD_W), .BEATS(BEATS)) b0 ();

    assign b1.flush = flush;           assign b0.flush = flush;
    assign b1.err_clr = err_clr;       assign b0.err_clr = err_clr;
    assign b1.in_pad_wenq = wenq;      assign b0.in_pad_wenq = wenq;
    assign b1.in_pad_wdata = wdata;    assign b0.in_pad_wdata = wdata;
    assign b1.in_word_ready = in_ready; assign b0.in_word_ready = in_ready;
    assign b1.out_word_valid = out_valid; assign b0.out_word_valid = out_valid;
    assign b1.out_word_data = out_data; assign b0.out_word_data = out_data;
    assign b1.out_pad_deq = deq;       assign b0.out_pad_deq = deq;

    io_word_bridge #(.PAD_W(PAD_W), .BEATS(BEATS), .DEPTH(DEPTH), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    io_word_bridge #(.PAD_W(PAD_W), .BEATS(BEATS), .DEPTH(DEPTH), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));

    // Reference state: words kept in LSB-first layout, partial word as a beat list.
    word_t m_in_q[$];
    beat_t m_part[$];
    word_t m_out_q[$];
    int    m_ob = 0;
    bit    m_ovf = 1'b0, m_udf = 1'b0;

    function automatic word_t mirror(input word_t w);
        word_t r = '0;
        for (int b = 0; b < BEATS; b++) r[(BEATS-1-b)*PAD_W +: PAD_W] = w[b*PAD_W +: PAD_W];
        return r;
    endfunction

    function automatic beat_t slice_of(input word_t w, input int b, input bit lsb);
        int pos = lsb ? b : BEATS - 1 - b;
        return w[pos*PAD_W +: PAD_W];
    endfunction

    task automatic m_reset();
        m_in_q.delete(); m_part.delete(); m_out_q.delete();
        m_ob = 0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_step();
        bit    wf, ovf_e, udf_e;
        int    out_sz;
        word_t w;
        wf     = (m_in_q.size() < DEPTH) || (m_part.size() != BEATS - 1);
        ovf_e  = wenq && !wf;
        udf_e  = deq && (m_out_q.size() == 0);
        out_sz = m_out_q.size();
        if (flush) begin
            m_in_q.delete(); m_part.delete(); m_out_q.delete(); m_ob = 0;
        end else begin
            if (in_ready && m_in_q.size() != 0) void'(m_in_q.pop_front());
            if (wenq && wf) begin
                m_part.push_back(wdata);
                if (m_part.size() == BEATS) begin
                    w = '0;
                    foreach (m_part[i]) w[i*PAD_W +: PAD_W] = m_part[i];
                    m_in_q.push_back(w);
                    m_part.delete();
                end
            end
            if (deq && out_sz != 0) begin
                if (m_ob == BEATS - 1) begin void'(m_out_q.pop_front()); m_ob = 0; end
                else m_ob++;
            end
            if (out_valid && out_sz < DEPTH) m_out_q.push_back(out_data);
        end
        m_ovf = ovf_e || (m_ovf && !err_clr);
        m_udf = udf_e || (m_udf && !err_clr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else m_reset();
        #1;
    endtask

    task automatic send_beat(input beat_t b);
        wenq = 1'b1; wdata = b; tick(); wenq = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (b1.in_pad_wfull_n !== 1'b1) begin fails++; $display("FAIL rst_wfull_n got %0h exp 1", b1.in_pad_wfull_n); end
        tests++; if (b1.in_word_valid !== 1'b0) begin fails++; $display("FAIL rst_in_valid got %0h exp 0", b1.in_word_valid); end
        tests++; if (b1.in_word_data !== '0) begin fails++; $display("FAIL rst_in_data got %0h exp 0", b1.in_word_data); end
        tests++; if (b1.out_word_ready !== 1'b1) begin fails++; $display("FAIL rst_out_ready got %0h exp 1", b1.out_word_ready); end
        tests++; if (b1.out_pad_rempty_n !== 1'b0) begin fails++; $display("FAIL rst_rempty_n got %0h exp 0", b1.out_pad_rempty_n); end
        tests++; if (b1.out_pad_rdata !== '0) begin fails++; $display("FAIL rst_rdata got %0h exp 0", b1.out_pad_rdata); end
        tests++; if ({b1.err_overflow, b1.err_underflow, b0.err_overflow, b0.err_underflow} !== 4'b0) begin fails++; $display("FAIL rst_errs got %b exp 0000", {b1.err_overflow, b1.err_underflow, b0.err_overflow, b0.err_underflow}); end
    endtask

    task automatic test_pack();
        word_t e1 = {11'h005, 11'h004, 11'h003, 11'h002, 11'h001};
        word_t e0 = {11'h001, 11'h002, 11'h003, 11'h004, 11'h005};
        for (int i = 1; i <= 4; i++) send_beat(beat_t'(i));
        tests++; if (b1.in_word_valid !== 1'b0) begin fails++; $display("FAIL pack_early_valid got %0h exp 0", b1.in_word_valid); end
        send_beat(beat_t'(5));
        tests++; if (b1.in_word_valid !== 1'b1) begin fails++; $display("FAIL pack_valid got %0h exp 1", b1.in_word_valid); end
        tests++; if (b1.in_word_data !== e1) begin fails++; $display("FAIL pack_data_lsb got %0h exp %0h", b1.in_word_data, e1); end
        tests++; if (b0.in_word_data !== e0) begin fails++; $display("FAIL pack_data_msb got %0h exp %0h", b0.in_word_data, e0); end
        in_ready = 1'b1; tick(); in_ready = 1'b0;
        tests++; if ({b1.in_word_valid, b0.in_word_valid} !== 2'b00) begin fails++; $display("FAIL pack_pop_valid got %b exp 00", {b1.in_word_valid, b0.in_word_valid}); end
        tests++; if (b1.in_word_data !== '0) begin fails++; $display("FAIL pack_empty_data got %0h exp 0", b1.in_word_data); end
    endtask

    task automatic test_overflow();
        word_t exp_w[5];
        beat_t bt;
        for (int k = 0; k < 5; k++) exp_w[k] = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < BEATS; j++) begin
                bt = beat_t'(k*16 + j + 1); exp_w[k][j*PAD_W +: PAD_W] = bt; send_beat(bt);
            end
        end
        for (int j = 0; j < 4; j++) begin
            bt = beat_t'(80 + j); exp_w[4][j*PAD_W +: PAD_W] = bt; send_beat(bt);
        end
        tests++; if (b1.in_pad_wfull_n !== 1'b0) begin fails++; $display("FAIL ovf_wfull_low got %0h exp 0", b1.in_pad_wfull_n); end
        tests++; if (b1.err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_err_before got %0h exp 0", b1.err_overflow); end
        send_beat(11'h7AA);
        tests++; if ({b1.err_overflow, b0.err_overflow} !== 2'b11) begin fails++; $display("FAIL ovf_err_set got %b exp 11", {b1.err_overflow, b0.err_overflow}); end
        tests++; if (b1.in_pad_wfull_n !== 1'b0) begin fails++; $display("FAIL ovf_wfull_hold got %0h exp 0", b1.in_pad_wfull_n); end
        tests++; if (b1.in_word_data !== exp_w[0]) begin fails++; $display("FAIL ovf_head0 got %0h exp %0h", b1.in_word_data, exp_w[0]); end
        in_ready = 1'b1; tick(); in_ready = 1'b0;
        tests++; if (b1.in_pad_wfull_n !== 1'b1) begin fails++; $display("FAIL ovf_wfull_pop got %0h exp 1", b1.in_pad_wfull_n); end
        bt = beat_t'(84); exp_w[4][4*PAD_W +: PAD_W] = bt; send_beat(bt);
        for (int k = 1; k < 5; k++) begin
            tests++; if (b1.in_word_data !== exp_w[k]) begin fails++; $display("FAIL ovf_word%0d_lsb got %0h exp %0h", k, b1.in_word_data, exp_w[k]); end
            tests++; if (b0.in_word_data !== mirror(exp_w[k])) begin fails++; $display("FAIL ovf_word%0d_msb got %0h exp %0h", k, b0.in_word_data, mirror(exp_w[k])); end
            in_ready = 1'b1; tick(); in_ready = 1'b0;
        end
        tests++; if (b1.in_word_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained got %0h exp 0", b1.in_word_valid); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tests++; if ({b1.err_overflow, b0.err_overflow} !== 2'b00) begin fails++; $display("FAIL ovf_err_clr got %b exp 00", {b1.err_overflow, b0.err_overflow}); end
    endtask

    task automatic test_unpack();
        word_t w = {11'h7FF, 11'h000, 11'h123, 11'h456, 11'h001};
        beat_t e1[5] = '{11'h001, 11'h456, 11'h123, 11'h000, 11'h7FF};
        beat_t e0[5] = '{11'h7FF, 11'h000, 11'h123, 11'h456, 11'h001};
        out_valid = 1'b1; out_data = w; tick(); out_valid = 1'b0;
        tests++; if (b1.out_pad_rempty_n !== 1'b1) begin fails++; $display("FAIL unp_rempty_n got %0h exp 1", b1.out_pad_rempty_n); end
        for (int i = 0; i < BEATS; i++) begin
            tests++; if (b1.out_pad_rdata !== e1[i]) begin fails++; $display("FAIL unp_beat%0d_lsb got %0h exp %0h", i, b1.out_pad_rdata, e1[i]); end
            tests++; if (b0.out_pad_rdata !== e0[i]) begin fails++; $display("FAIL unp_beat%0d_msb got %0h exp %0h", i, b0.out_pad_rdata, e0[i]); end
            deq = 1'b1; tick(); deq = 1'b0;
        end
        tests++; if ({b1.out_pad_rempty_n, b0.out_pad_rempty_n} !== 2'b00) begin fails++; $display("FAIL unp_empty got %b exp 00", {b1.out_pad_rempty_n, b0.out_pad_rempty_n}); end
        tests++; if (b1.err_underflow !== 1'b0) begin fails++; $display("FAIL unp_err_before got %0h exp 0", b1.err_underflow); end
        deq = 1'b1; tick(); deq = 1'b0;
        tests++; if ({b1.err_underflow, b0.err_underflow} !== 2'b11) begin fails++; $display("FAIL unp_err_set got %b exp 11", {b1.err_underflow, b0.err_underflow}); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        tests++; if (b1.err_underflow !== 1'b0) begin fails++; $display("FAIL unp_err_clr got %0h exp 0", b1.err_underflow); end
    endtask

    task automatic test_flush();
        word_t ew = {11'h014, 11'h013, 11'h012, 11'h011, 11'h010};
        word_t w1 = word_t'({$urandom(), $urandom()});
        word_t w2 = word_t'({$urandom(), $urandom()});
        word_t w3 = word_t'({$urandom(), $urandom()});
        for (int j = 0; j < 3; j++) send_beat(beat_t'(11'h0A0 + j));
        flush = 1'b1; wenq = 1'b1; wdata = 11'h155; tick(); flush = 1'b0; wenq = 1'b0;
        for (int j = 0; j < BEATS; j++) send_beat(beat_t'(11'h010 + j));
        tests++; if (b1.in_word_data !== ew) begin fails++; $display("FAIL fl_clean_word got %0h exp %0h", b1.in_word_data, ew); end
        in_ready = 1'b1; tick(); in_ready = 1'b0;
        deq = 1'b1; tick(); deq = 1'b0;
        out_valid = 1'b1; out_data = w1; tick(); out_data = w2; tick(); out_valid = 1'b0;
        deq = 1'b1; tick(); deq = 1'b0;
        tests++; if (b1.out_pad_rdata !== w1[21:11]) begin fails++; $display("FAIL fl_beat1 got %0h exp %0h", b1.out_pad_rdata, w1[21:11]); end
        flush = 1'b1; tick(); flush = 1'b0;
        tests++; if (b1.out_pad_rempty_n !== 1'b0) begin fails++; $display("FAIL fl_rempty_n got %0h exp 0", b1.out_pad_rempty_n); end
        tests++; if (b1.out_word_ready !== 1'b1) begin fails++; $display("FAIL fl_out_ready got %0h exp 1", b1.out_word_ready); end
        tests++; if (b1.err_underflow !== 1'b1) begin fails++; $display("FAIL fl_err_kept got %0h exp 1", b1.err_underflow); end
        out_valid = 1'b1; out_data = w3; tick(); out_valid = 1'b0;
        tests++; if (b1.out_pad_rdata !== w3[10:0]) begin fails++; $display("FAIL fl_ob_restart got %0h exp %0h", b1.out_pad_rdata, w3[10:0]); end
        flush = 1'b1; err_clr = 1'b1; tick(); flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_random();
        word_t e_ih, e_oh;
        bit    e_wf;
        for (int c = 0; c < 1500; c++) begin
            e_wf = (m_in_q.size() < DEPTH) || (m_part.size() != BEATS - 1);
            e_ih = (m_in_q.size() != 0) ? m_in_q[0] : '0;
            e_oh = (m_out_q.size() != 0) ? m_out_q[0] : '0;
            tests++; if ({b1.in_pad_wfull_n, b0.in_pad_wfull_n} !== {e_wf, e_wf}) begin fails++; $display("FAIL rnd_wfull_n cyc %0d got %b exp %b", c, {b1.in_pad_wfull_n, b0.in_pad_wfull_n}, {e_wf, e_wf}); end
            tests++; if (b1.in_word_valid !== (m_in_q.size() != 0)) begin fails++; $display("FAIL rnd_in_valid cyc %0d got %0h exp %0h", c, b1.in_word_valid, m_in_q.size() != 0); end
            tests++; if (b1.in_word_data !== e_ih) begin fails++; $display("FAIL rnd_in_data_lsb cyc %0d got %0h exp %0h", c, b1.in_word_data, e_ih); end
            tests++; if (b0.in_word_data !== mirror(e_ih)) begin fails++; $display("FAIL rnd_in_data_msb cyc %0d got %0h exp %0h", c, b0.in_word_data, mirror(e_ih)); end
            tests++; if (b1.out_word_ready !== (m_out_q.size() < DEPTH)) begin fails++; $display("FAIL rnd_out_ready cyc %0d got %0h exp %0h", c, b1.out_word_ready, m_out_q.size() < DEPTH); end
            tests++; if (b1.out_pad_rempty_n !== (m_out_q.size() != 0)) begin fails++; $display("FAIL rnd_rempty_n cyc %0d got %0h exp %0h", c, b1.out_pad_rempty_n, m_out_q.size() != 0); end
            tests++; if (b1.out_pad_rdata !== slice_of(e_oh, m_ob, 1'b1)) begin fails++; $display("FAIL rnd_rdata_lsb cyc %0d got %0h exp %0h", c, b1.out_pad_rdata, slice_of(e_oh, m_ob, 1'b1)); end
            tests++; if (b0.out_pad_rdata !== slice_of(e_oh, m_ob, 1'b0)) begin fails++; $display("FAIL rnd_rdata_msb cyc %0d got %0h exp %0h", c, b0.out_pad_rdata, slice_of(e_oh, m_ob, 1'b0)); end
            tests++; if ({b1.err_overflow, b1.err_underflow, b0.err_overflow, b0.err_underflow} !== {m_ovf, m_udf, m_ovf, m_udf}) begin fails++; $display("FAIL rnd_errs cyc %0d got %b exp %b", c, {b1.err_overflow, b1.err_underflow, b0.err_overflow, b0.err_underflow}, {m_ovf, m_udf, m_ovf, m_udf}); end
            wenq      = ($urandom_range(0, 99) < 60);
            wdata     = beat_t'($urandom());
            in_ready  = ($urandom_range(0, 99) < 30);
            out_valid = ($urandom_range(0, 99) < 40);
            out_data  = word_t'({$urandom(), $urandom()});
            deq       = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 2);
            err_clr   = ($urandom_range(0, 99) < 4);
            tick();
        end
        {wenq, in_ready, out_valid, deq, flush, err_clr} = '0;
    endtask

    task automatic test_async_reset();
        word_t ew = {11'h025, 11'h024, 11'h023, 11'h022, 11'h021};
        for (int j = 0; j < 12; j++) send_beat(beat_t'(11'h300 + j));
        out_valid = 1'b1; out_data = word_t'({$urandom(), $urandom()}); tick(); tick(); out_valid = 1'b0;
        deq = 1'b1; tick(); deq = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({b1.in_pad_wfull_n, b1.in_word_valid, b1.out_word_ready, b1.out_pad_rempty_n} !== 4'b1010) begin fails++; $display("FAIL arst_flags got %b exp 1010", {b1.in_pad_wfull_n, b1.in_word_valid, b1.out_word_ready, b1.out_pad_rempty_n}); end
        tests++; if (b1.in_word_data !== '0 || b0.in_word_data !== '0) begin fails++; $display("FAIL arst_in_data got %0h/%0h exp 0", b1.in_word_data, b0.in_word_data); end
        tests++; if (b1.out_pad_rdata !== '0 || b0.out_pad_rdata !== '0) begin fails++; $display("FAIL arst_rdata got %0h/%0h exp 0", b1.out_pad_rdata, b0.out_pad_rdata); end
        m_reset();
        @(negedge clk); rst_n = 1'b1;
        tick();
        tests++; if (b1.in_word_valid !== 1'b0) begin fails++; $display("FAIL arst_no_word got %0h exp 0", b1.in_word_valid); end
        for (int j = 0; j < BEATS; j++) send_beat(beat_t'(11'h021 + j));
        tests++; if (b1.in_word_data !== ew) begin fails++; $display("FAIL arst_clean_word got %0h exp %0h", b1.in_word_data, ew); end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
        test_reset();
        test_pack();
        test_overflow();
        test_unpack();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_word_bridge.md
Name: io_word_bridge

Overview:
Parametrised pad-to-core streaming bridge for the accelerator's host IO port. Generalises the fixed 11-bit in/out FIFO pin path to configurable pad width and beats-per-word, with an inbound word packer and an outbound word unpacker. Each direction has a DEPTH-entry word FIFO, selectable beat order, flush, and sticky overflow/underflow error flags. Sits between the IO pad assignments and the accelerator core, all in the core clock domain.

Parameters:
PAD_W, 11, pad data width per beat (bits)
BEATS, 5, pad beats per core word; WORD_W = PAD_W*BEATS (default 55 = one query patch)
DEPTH, 4, entries per word FIFO; power of two, >= 2
LSB_FIRST, 1, 1: beat 0 maps to word bits [PAD_W-1:0]; 0: beat 0 maps to the MSB slice

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of both paths
err_clr  input  1  synchronous clear of the sticky error flags
in_pad_wenq  input  1  inbound beat enqueue strobe
in_pad_wdata  input  PAD_W  inbound beat data
in_pad_wfull_n  output  1  high when an inbound beat can be accepted
in_word_valid  output  1  inbound FIFO non-empty
in_word_data  output  WORD_W  inbound FIFO head word
in_word_ready  input  1  core pops the inbound head
out_word_valid  input  1  core pushes an outbound word
out_word_data  input  WORD_W  outbound word
out_word_ready  output  1  outbound FIFO not full
out_pad_deq  input  1  outbound beat dequeue strobe
out_pad_rdata  output  PAD_W  current outbound beat
out_pad_rempty_n  output  1  outbound beat available
err_overflow  output  1  sticky: enqueue attempted while in_pad_wfull_n low
err_underflow  output  1  sticky: dequeue attempted while out_pad_rempty_n low

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, both beat counters 0, shift register 0, errors 0. Outputs: in_pad_wfull_n=1, in_word_valid=0, in_word_data=0, out_word_ready=1, out_pad_rempty_n=0, out_pad_rdata=0.
- Inbound packer: beat counter ib_cnt 0..BEATS-1. Accepted beat (wenq & wfull_n) writes slice ib_cnt (mirrored when LSB_FIRST=0), ib_cnt increments. On beat BEATS-1 the assembled word (including the current beat) is written to the FIFO at the same edge; ib_cnt wraps to 0.
- in_pad_wfull_n = (in_count < DEPTH) | (ib_cnt != BEATS-1). Combinational from registered state only; no path from in_word_ready.
- wenq while wfull_n low: beat dropped, ib_cnt unchanged, err_overflow set next edge.
- Inbound FIFO: in_word_valid = count!=0; in_word_data = head, 0 when empty. Pop on in_word_valid & in_word_ready. Simultaneous push and pop: count unchanged, both pointers advance. Pop when empty is ignored.
- Outbound FIFO: push on out_word_valid & out_word_ready; push when full is ignored (no error; core must honour ready). out_word_ready = out_count < DEPTH.
- Outbound unpacker: beat counter ob_cnt. out_pad_rempty_n = out_count!=0; out_pad_rdata = slice ob_cnt of head (order per LSB_FIRST), 0 when empty. Accepted deq increments ob_cnt; on beat BEATS-1 the head pops and ob_cnt wraps to 0. Simultaneous push and last-beat pop: count unchanged.
- deq while rempty_n low: ignored, err_underflow set.
- flush: next edge both FIFOs empty, pointers and beat counters 0, partial inbound word discarded; errors untouched. flush takes priority over same-cycle push/pop/beat activity.
- err_clr clears both flags; a new error in the same cycle wins (flag stays 1).
- Latency: last inbound beat to in_word_valid = 1 cycle; outbound push to out_pad_rempty_n = 1 cycle.
- Reset mid-word: partial data lost, no word emitted.

Test Plan:
- Pack, LSB_FIRST=1: beats 0x001..0x005 -> one cycle after 5th beat in_word_valid=1, in_word_data={0x005,0x004,0x003,0x002,0x001}; ready pop -> valid=0.
- Overflow: push 4 words without pops, 5th word beats 0..3 accepted, at ib_cnt=4 wfull_n=0; wenq -> err_overflow=1, ib_cnt stays 4; one pop -> wfull_n=1, final beat accepted, count stays 4; err_clr -> 0.
- Unpack: push word {0x7FF,0x000,0x123,0x456,0x001} -> out_pad_rdata 0x001,0x456,0x123,0x000,0x7FF on successive deqs; then rempty_n=0; extra deq -> err_underflow=1.
- LSB_FIRST=0: beats 0x001..0x005 -> in_word_data={0x001,0x002,0x003,0x004,0x005}; outbound mirrors.
- Flush mid-word: 3 beats, flush -> ib_cnt=0; next 5 beats form a clean word; outbound with 2 words queued, flush -> rempty_n=0, out_word_ready=1, errors unchanged.
- Async reset mid-operation with both FIFOs partially full -> all outputs at reset values immediately, no clock required.
